// File: rtl/or1k_dbg_pkg.sv
// Shared constants and types for the OR1K debug SPR register group.
package or1k_dbg_pkg;

  localparam int DBG_REASON_W = 14;

  localparam logic [4:0]  DBG_SPR_GROUP = 5'd6;

  localparam logic [10:0] DBG_IDX_DMR1 = 11'h010;
  localparam logic [10:0] DBG_IDX_DMR2 = 11'h011;
  localparam logic [10:0] DBG_IDX_DSR  = 11'h014;
  localparam logic [10:0] DBG_IDX_DRR  = 11'h015;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dbg_state_e;

endpackage

// File: rtl/or1k_dbg_spr_responder_drr.sv
// Debug reason register: sticky event capture with write-1-to-clear, plus the
// stall request raised when a recorded reason is enabled in DSR.
module or1k_dbg_drr
  import or1k_dbg_pkg::*;
(
  input  logic                    cpu_clk_i,
  input  logic                    rst_i,
  input  logic [DBG_REASON_W-1:0] evt_i,
  input  logic [DBG_REASON_W-1:0] clr_i,
  input  logic [DBG_REASON_W-1:0] dsr_i,
  output logic [DBG_REASON_W-1:0] drr_o,
  output logic                    stall_o
);

  logic [DBG_REASON_W-1:0] drr_r;
  logic                    stall_r;

  // A new event outranks a clear of the same bit; stall follows the updated DRR one edge later.
  always_ff @(posedge cpu_clk_i or posedge rst_i) begin
    if (rst_i) begin
      drr_r   <= {DBG_REASON_W{1'b0}};
      stall_r <= 1'b0;
    end else begin
      drr_r   <= (drr_r & ~clr_i) | evt_i;
      stall_r <= |(drr_r & dsr_i);
    end
  end

  assign drr_o   = drr_r;
  assign stall_o = stall_r;

endmodule

// File: rtl/or1k_dbg_spr_responder.sv
// SPR-bus responder for the OR1K debug group: holds DMR1/DMR2/DSR/DRR and
// acknowledges every access after WAIT_CYCLES wait states.
module or1k_dbg_spr_responder
  import or1k_dbg_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [4:0]  SPR_GROUP   = DBG_SPR_GROUP
) (
  input  logic                    cpu_clk_i,
  input  logic                    rst_i,
  input  logic                    spr_stb_i,
  input  logic                    spr_we_i,
  input  logic [31:0]             spr_addr_i,
  input  logic [31:0]             spr_data_i,
  output logic [31:0]             spr_data_o,
  output logic                    spr_ack_o,
  input  logic [DBG_REASON_W-1:0] evt_i,
  output logic [31:0]             dmr1_o,
  output logic [31:0]             dmr2_o,
  output logic [DBG_REASON_W-1:0] dsr_o,
  output logic                    stall_o
);

  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 32'd0);
  localparam logic [3:0] CNT_LOAD  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 32'd1);

  dbg_state_e              state_r;
  logic [3:0]              cnt_r;
  logic [15:0]             addr_r;
  logic                    we_r;
  logic [31:0]             wdata_r;
  logic [31:0]             rdata_r;
  logic [31:0]             dmr1_r;
  logic [31:0]             dmr2_r;
  logic [DBG_REASON_W-1:0] dsr_r;
  logic [DBG_REASON_W-1:0] drr_s;
  logic [DBG_REASON_W-1:0] drr_clr_s;

  logic [15:0]             acc_addr_s;
  logic                    acc_we_s;
  logic [31:0]             acc_data_s;
  logic                    ack_s;
  logic                    hit_s;
  logic                    commit_s;
  logic [10:0]             idx_s;
  logic [31:0]             rd_val_s;
  logic                    unused_s;

  assign unused_s = ^spr_addr_i[31:16];

  // With zero wait states the live bus is the access; otherwise the latched copy is.
  always_comb begin
    if (ZERO_WAIT) begin
      acc_addr_s = spr_addr_i[15:0];
      acc_we_s   = spr_we_i;
      acc_data_s = spr_data_i;
      ack_s      = spr_stb_i & (state_r == IDLE);
    end else begin
      acc_addr_s = addr_r;
      acc_we_s   = we_r;
      acc_data_s = wdata_r;
      ack_s      = (state_r == ACK);
    end
  end

  assign hit_s     = (acc_addr_s[15:11] == SPR_GROUP);
  assign idx_s     = acc_addr_s[10:0];
  assign commit_s  = ack_s & acc_we_s & hit_s;
  assign drr_clr_s = (commit_s && (idx_s == DBG_IDX_DRR)) ? acc_data_s[DBG_REASON_W-1:0]
                                                           : {DBG_REASON_W{1'b0}};

  // Read multiplexer over the current register contents.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    if (hit_s) begin
      case (idx_s)
        DBG_IDX_DMR1: rd_val_s = dmr1_r;
        DBG_IDX_DMR2: rd_val_s = dmr2_r;
        DBG_IDX_DSR:  rd_val_s = {{(32-DBG_REASON_W){1'b0}}, dsr_r};
        DBG_IDX_DRR:  rd_val_s = {{(32-DBG_REASON_W){1'b0}}, drr_s};
        default:      rd_val_s = 32'h0000_0000;
      endcase
    end else begin
      rd_val_s = 32'h0000_0000;
    end
  end

  // Access sequencer: latch in IDLE, count wait states, one ack cycle.
  always_ff @(posedge cpu_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= 16'h0000;
      we_r    <= 1'b0;
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (spr_stb_i && !ZERO_WAIT) begin
            addr_r  <= spr_addr_i[15:0];
            we_r    <= spr_we_i;
            wdata_r <= spr_data_i;
            cnt_r   <= CNT_LOAD;
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            rdata_r <= rd_val_s;
            state_r <= ACK;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ACK:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Mode/status registers commit on the acknowledging edge.
  always_ff @(posedge cpu_clk_i or posedge rst_i) begin
    if (rst_i) begin
      dmr1_r <= 32'h0000_0000;
      dmr2_r <= 32'h0000_0000;
      dsr_r  <= {DBG_REASON_W{1'b0}};
    end else if (commit_s) begin
      case (idx_s)
        DBG_IDX_DMR1: dmr1_r <= acc_data_s;
        DBG_IDX_DMR2: dmr2_r <= acc_data_s;
        DBG_IDX_DSR:  dsr_r  <= acc_data_s[DBG_REASON_W-1:0];
        default:      ;
      endcase
    end
  end

  or1k_dbg_drr u_drr (
    .cpu_clk_i (cpu_clk_i),
    .rst_i     (rst_i),
    .evt_i     (evt_i),
    .clr_i     (drr_clr_s),
    .dsr_i     (dsr_r),
    .drr_o     (drr_s),
    .stall_o   (stall_o)
  );

  assign spr_ack_o  = ack_s;
  assign spr_data_o = ack_s ? (ZERO_WAIT ? rd_val_s : rdata_r) : 32'h0000_0000;
  assign dmr1_o     = dmr1_r;
  assign dmr2_o     = dmr2_r;
  assign dsr_o      = dsr_r;

endmodule

// File: tb/tb_or1k_dbg_spr_responder.sv
// Bench for or1k_dbg_spr_responder: a zero-wait and a two-wait instance checked
// every cycle against an edge-counting transaction model, plus directed cases.
`timescale 1ns/1ps
module tb_or1k_dbg_spr_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb  [2];
  logic        we   [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [13:0] evt  [2];
  logic        ack  [2];
  logic [31:0] rdat [2];
  logic [31:0] dmr1 [2];
  logic [31:0] dmr2 [2];
  logic [13:0] dsr  [2];
  logic        stall[2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  or1k_dbg_spr_responder #(.WAIT_CYCLES(0)) dut0 (
    .cpu_clk_i(clk), .rst_i(rst), .spr_stb_i(stb[0]), .spr_we_i(we[0]),
    .spr_addr_i(addr[0]), .spr_data_i(wdat[0]), .spr_data_o(rdat[0]), .spr_ack_o(ack[0]),
    .evt_i(evt[0]), .dmr1_o(dmr1[0]), .dmr2_o(dmr2[0]), .dsr_o(dsr[0]), .stall_o(stall[0]));

  or1k_dbg_spr_responder #(.WAIT_CYCLES(2)) dut2 (
    .cpu_clk_i(clk), .rst_i(rst), .spr_stb_i(stb[1]), .spr_we_i(we[1]),
    .spr_addr_i(addr[1]), .spr_data_i(wdat[1]), .spr_data_o(rdat[1]), .spr_ack_o(ack[1]),
    .evt_i(evt[1]), .dmr1_o(dmr1[1]), .dmr2_o(dmr2[1]), .dsr_o(dsr[1]), .stall_o(stall[1]));

  // Reference model state, one slot per instance.
  logic [31:0] m_dmr1 [2];
  logic [31:0] m_dmr2 [2];
  logic [13:0] m_dsr  [2];
  logic [13:0] m_drr  [2];
  logic        m_stall[2];
  logic        busy   [2];
  int          acc    [2];
  logic        l_we   [2];
  logic [31:0] l_addr [2];
  logic [31:0] l_dat  [2];
  logic [31:0] snap   [2];
  int          edge_cnt;

  function automatic int nw(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic [31:0] mrd(input int d, input logic [31:0] a);
    if (a[15:11] != 5'd6) return 32'h0;
    case (a[10:0])
      11'h010: return m_dmr1[d];
      11'h011: return m_dmr2[d];
      11'h014: return {18'h0, m_dsr[d]};
      11'h015: return {18'h0, m_drr[d]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  // Model: accept at edge k, ack in the cycle after edge k+N, write lands at edge k+N+1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt = 0;
      for (int d = 0; d < 2; d++) begin
        m_dmr1[d] = 32'h0; m_dmr2[d] = 32'h0; m_dsr[d] = 14'h0; m_drr[d] = 14'h0;
        m_stall[d] = 1'b0; busy[d] = 1'b0; acc[d] = 0; snap[d] = 32'h0;
        l_we[d] = 1'b0; l_addr[d] = 32'h0; l_dat[d] = 32'h0;
      end
    end else begin
      edge_cnt++;
      for (int d = 0; d < 2; d++) begin
        logic        wr;
        logic [31:0] wa, wd;
        logic [13:0] clr;
        logic        st;
        wr = 1'b0; wa = 32'h0; wd = 32'h0; clr = 14'h0;
        st = |(m_drr[d] & m_dsr[d]);
        if (nw(d) == 0) begin
          if (stb[d]) begin wr = we[d]; wa = addr[d]; wd = wdat[d]; end
        end else if (busy[d]) begin
          if (edge_cnt == acc[d] + nw(d)) snap[d] = mrd(d, l_addr[d]);
          else if (edge_cnt == acc[d] + nw(d) + 1) begin
            wr = l_we[d]; wa = l_addr[d]; wd = l_dat[d]; busy[d] = 1'b0;
          end
        end else if (stb[d]) begin
          busy[d] = 1'b1; acc[d] = edge_cnt;
          l_we[d] = we[d]; l_addr[d] = addr[d]; l_dat[d] = wdat[d];
        end
        if (wr && wa[15:11] == 5'd6) begin
          case (wa[10:0])
            11'h010: m_dmr1[d] = wd;
            11'h011: m_dmr2[d] = wd;
            11'h014: m_dsr[d]  = wd[13:0];
            11'h015: clr       = wd[13:0];
            default: ;
          endcase
        end
        m_drr[d]   = (m_drr[d] & ~clr) | evt[d];
        m_stall[d] = st;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        logic ea;
        ea = (nw(d) == 0) ? stb[d] : (busy[d] && edge_cnt == acc[d] + nw(d));
        chk("ack", d, {31'h0, ack[d]}, {31'h0, ea});
        if (ea) chk("rdata", d, rdat[d], (nw(d) == 0) ? mrd(d, addr[d]) : snap[d]);
        chk("dmr1", d, dmr1[d], m_dmr1[d]);
        chk("dmr2", d, dmr2[d], m_dmr2[d]);
        chk("dsr", d, {18'h0, dsr[d]}, {18'h0, m_dsr[d]});
        chk("stall", d, {31'h0, stall[d]}, {31'h0, m_stall[d]});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input int d, input logic [13:0] v);
    evt[d] = v; tick(); evt[d] = 14'h0;
  endtask

  // One bus access; ev_ack is driven on evt during the ack cycle.
  task automatic access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [13:0] ev_ack, output logic [31:0] rd, output int lat);
    int  n;
    bit  got;
    stb[d] = 1'b1; we[d] = w; addr[d] = a; wdat[d] = wd;
    got = 1'b0; lat = -1; rd = 32'h0; n = 0;
    while (n < 20 && !got) begin
      @(negedge clk);
      if (ack[d]) begin got = 1'b1; lat = n; rd = rdat[d]; evt[d] = ev_ack; end
      n++;
    end
    tick();
    stb[d] = 1'b0; we[d] = 1'b0; evt[d] = 14'h0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout dut%0d: got no ack expected ack within 20 cycles", d);
    end
  endtask

  initial begin
    logic [31:0] r, a, wd, tmp;
    logic [13:0] ev;
    logic        w;
    int          lat, d, k;

    for (int i = 0; i < 2; i++) begin
      stb[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; wdat[i] = 32'h0; evt[i] = 14'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack", i, {31'h0, ack[i]}, 32'h0);
      chk("rst_data", i, rdat[i], 32'h0);
      chk("rst_dmr1", i, dmr1[i], 32'h0);
      chk("rst_stall", i, {31'h0, stall[i]}, 32'h0);
    end
    tick();

    // Reset while the two-wait instance is in its wait phase.
    stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_3010; wdat[1] = 32'h1234_5678;
    tick(); tick();
    rst = 1'b1; stb[1] = 1'b0; we[1] = 1'b0;
    tick();
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("ack_after_rst", 1, {31'h0, ack[1]}, 32'h0);
    end
    tick();
    access(1, 1'b0, 32'h0000_3010, 32'h0, 14'h0, r, lat);
    chk("dmr1_after_rst", 1, r, 32'h0);
    chk("stall_after_rst", 1, {31'h0, stall[1]}, 32'h0);

    // Two wait states: write then read DMR1.
    access(1, 1'b1, 32'h0000_3010, 32'hA5A5_1234, 14'h0, r, lat);
    chk("wr_latency", 1, lat, 32'd3);
    chk("dmr1_o", 1, dmr1[1], 32'hA5A5_1234);
    access(1, 1'b0, 32'h0000_3010, 32'h0, 14'h0, r, lat);
    chk("rd_latency", 1, lat, 32'd3);
    chk("rd_dmr1", 1, r, 32'hA5A5_1234);

    // Zero wait states: write then read DMR2.
    access(0, 1'b1, 32'h0000_3011, 32'hDEAD_BEEF, 14'h0, r, lat);
    chk("wr_latency", 0, lat, 32'd0);
    chk("dmr2_o", 0, dmr2[0], 32'hDEAD_BEEF);
    access(0, 1'b0, 32'h0000_3011, 32'h0, 14'h0, r, lat);
    chk("rd_latency", 0, lat, 32'd0);
    chk("rd_dmr2", 0, r, 32'hDEAD_BEEF);

    // Unmapped group and unmapped index.
    access(1, 1'b1, 32'h0000_2010, 32'hFFFF_FFFF, 14'h0, r, lat);
    access(1, 1'b1, 32'h0000_3012, 32'hFFFF_FFFF, 14'h0, r, lat);
    access(1, 1'b0, 32'h0000_2010, 32'h0, 14'h0, r, lat);
    chk("rd_unmapped_grp", 1, r, 32'h0);
    access(1, 1'b0, 32'h0000_3012, 32'h0, 14'h0, r, lat);
    chk("rd_unmapped_idx", 1, r, 32'h0);
    chk("dmr1_kept", 1, dmr1[1], 32'hA5A5_1234);
    chk("dmr2_kept", 1, dmr2[1], 32'h0);

    // Enabled event raises stall one cycle after DRR records it.
    access(1, 1'b1, 32'h0000_3014, 32'h0000_0008, 14'h0, r, lat);
    pulse(1, 14'h0008);
    @(negedge clk);
    chk("stall_not_yet", 1, {31'h0, stall[1]}, 32'h0);
    @(posedge clk); #1;
    chk("stall_set", 1, {31'h0, stall[1]}, 32'h1);
    access(1, 1'b0, 32'h0000_3015, 32'h0, 14'h0, r, lat);
    chk("drr_set", 1, r, 32'h0000_0008);
    access(1, 1'b1, 32'h0000_3015, 32'h0000_0008, 14'h0008, r, lat);
    access(1, 1'b0, 32'h0000_3015, 32'h0, 14'h0, r, lat);
    chk("drr_set_wins", 1, r, 32'h0000_0008);
    chk("stall_held", 1, {31'h0, stall[1]}, 32'h1);
    access(1, 1'b1, 32'h0000_3015, 32'h0000_0008, 14'h0, r, lat);
    access(1, 1'b0, 32'h0000_3015, 32'h0, 14'h0, r, lat);
    chk("drr_cleared", 1, r, 32'h0);
    chk("stall_cleared", 1, {31'h0, stall[1]}, 32'h0);

    // Disabled event: recorded but no stall.
    access(1, 1'b1, 32'h0000_3014, 32'h0, 14'h0, r, lat);
    pulse(1, 14'h0001);
    tick(); tick();
    chk("stall_disabled", 1, {31'h0, stall[1]}, 32'h0);
    access(1, 1'b0, 32'h0000_3015, 32'h0, 14'h0, r, lat);
    chk("drr_bit0", 1, r, 32'h0000_0001);

    // Randomized traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      d   = i % 2;
      tmp = $urandom();
      k   = $urandom_range(0, 5);
      case (k)
        0:       a = {tmp[31:16], 5'd6, 11'h010};
        1:       a = {tmp[31:16], 5'd6, 11'h011};
        2:       a = {tmp[31:16], 5'd6, 11'h014};
        3:       a = {tmp[31:16], 5'd6, 11'h015};
        4:       a = tmp;
        default: a = {tmp[31:16], tmp[15:11], 11'h015};
      endcase
      wd = $urandom();
      w  = 1'($urandom_range(0, 1));
      ev = ($urandom_range(0, 3) == 0) ? 14'($urandom()) : 14'h0;
      if ($urandom_range(0, 2) == 0) pulse(d, 14'($urandom()));
      access(d, w, a, wd, ev, r, lat);
      chk("rand_latency", d, lat, (d == 0) ? 32'd0 : 32'd3);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
